// File: rtl/stream_pool_pkg.sv
// Shared CNN defines for the pooling block.
// Holds the default channel count, sample width and pool size, the
// pooling-mode encoding, and helpers for the legal pool sizes.
package stream_pool_pkg;

    localparam int CNN_CI     = 3;
    localparam int CNN_IF_BW  = 8;
    localparam int CNN_POOL_K = 2;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // Only 2x2 and 4x4 windows are supported.
    function automatic bit pool_k_legal(input int k);
        return (k == 2) || (k == 4);
    endfunction

    function automatic int pool_k_log2(input int k);
        return (k == 4) ? 2 : 1;
    endfunction

endpackage

// File: rtl/stream_pool_acc_lane.sv
// pool_acc_lane: one channel of the pooling datapath.
// Holds this channel's column of the partial-result buffer (DEPTH
// accumulators) and produces the pooled value for the window being
// updated, including the current sample.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_en        - update accumulator i_idx with i_sample
//   i_first     - sample is the first of its window (re-initialise)
//   i_mode      - max / average for the current frame
//   i_idx       - window column (col / POOL_K)
//   i_sample    - signed channel sample
//   o_res       - pooled result from the accumulator's next value
module pool_acc_lane
    import stream_pool_pkg::*;
#(
    parameter int IF_BW = 8,
    parameter int SH    = 2,
    parameter int ACC_W = IF_BW + SH,
    parameter int DEPTH = 14,
    parameter int IW    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic                    i_first,
    input  pool_mode_e              i_mode,
    input  logic [IW-1:0]           i_idx,
    input  logic signed [IF_BW-1:0] i_sample,
    output logic [IF_BW-1:0]        o_res
);

    logic signed [ACC_W-1:0] r_acc [DEPTH];
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_prev;
    logic signed [ACC_W-1:0] w_new;

    assign w_ext  = {{(ACC_W-IF_BW){i_sample[IF_BW-1]}}, i_sample};
    assign w_prev = r_acc[i_idx];

    always_comb begin
        w_new = w_ext;
        if (!i_first) begin
            if (i_mode == POOL_AVG)
                w_new = w_prev + w_ext;
            else if (w_ext > w_prev)
                w_new = w_ext;
            else
                w_new = w_prev;
        end
    end

    // ACC_W = IF_BW + SH, so the top IF_BW bits are exactly the
    // arithmetic right shift by SH truncated to IF_BW (floor division).
    assign o_res = (i_mode == POOL_AVG) ? w_new[SH +: IF_BW] : w_new[IF_BW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_acc[i] <= '0;
        end else if (i_en) begin
            r_acc[i_idx] <= w_new;
        end
    end

endmodule

// File: rtl/stream_pool.sv
// stream_pool: streaming max / average pooling over a raster pixel stream.
// Pixels arrive column-fastest; each non-overlapping POOL_K x POOL_K window
// yields one pooled pixel, one cycle after its last pixel is accepted.
// Trailing columns/rows outside the last full window are accepted and dropped.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   i_mode                  - 0 max, 1 average; latched at the frame's first pixel
//   i_in_valid/o_in_ready   - input handshake, i_in_pix channel c at [c*IF_BW +: IF_BW]
//   o_ot_valid/i_ot_ready   - output handshake, o_ot_pix same packing
//   o_ot_last               - marks the final pooled pixel of the frame
module stream_pool
    import stream_pool_pkg::*;
#(
    parameter int CI     = CNN_CI,
    parameter int IF_BW  = CNN_IF_BW,
    parameter int IN_W   = 28,
    parameter int IN_H   = 28,
    parameter int POOL_K = CNN_POOL_K
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_mode,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [CI*IF_BW-1:0]   i_in_pix,
    output logic                  o_ot_valid,
    input  logic                  i_ot_ready,
    output logic [CI*IF_BW-1:0]   o_ot_pix,
    output logic                  o_ot_last
);

    localparam int OUT_W = IN_W / POOL_K;
    localparam int OUT_H = IN_H / POOL_K;
    localparam int KB    = pool_k_log2(POOL_K);
    localparam int ACC_W = IF_BW + 2*KB;
    localparam int CW    = $clog2(IN_W + 1);
    localparam int RW    = $clog2(IN_H + 1);
    localparam int IW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IN_H - 1);
    localparam logic [CW-1:0] COL_LIM   = CW'(OUT_W * POOL_K);
    localparam logic [RW-1:0] ROW_LIM   = RW'(OUT_H * POOL_K);
    localparam logic [CW-1:0] COL_WLAST = CW'(OUT_W * POOL_K - 1);
    localparam logic [RW-1:0] ROW_WLAST = RW'(OUT_H * POOL_K - 1);

    if (!pool_k_legal(POOL_K)) begin : g_bad_k
        $error("stream_pool: POOL_K must be 2 or 4");
    end

    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    pool_mode_e           r_mode;
    logic                 r_ot_valid;
    logic                 r_ot_last;
    logic [CI*IF_BW-1:0]  r_ot_pix;

    logic                 w_accept;
    logic                 w_frame_start;
    pool_mode_e           w_mode;
    logic                 w_in_win;
    logic                 w_first;
    logic                 w_done;
    logic                 w_en;
    logic                 w_last;
    logic [IW-1:0]        w_idx;
    logic [CI*IF_BW-1:0]  w_res;

    // A completing pixel may enter while the held output drains.
    assign o_in_ready = ~(r_ot_valid & ~i_ot_ready);
    assign w_accept   = i_in_valid & o_in_ready;

    // The first pixel of a frame already uses the incoming mode.
    assign w_frame_start = (r_col == '0) && (r_row == '0);
    assign w_mode        = w_frame_start ? pool_mode_e'(i_mode) : r_mode;

    assign w_in_win = (r_col < COL_LIM) && (r_row < ROW_LIM);
    assign w_first  = (r_col[KB-1:0] == '0) && (r_row[KB-1:0] == '0);
    assign w_done   = w_accept && w_in_win && (&r_col[KB-1:0]) && (&r_row[KB-1:0]);
    assign w_en     = w_accept && w_in_win;
    assign w_last   = (r_col == COL_WLAST) && (r_row == ROW_WLAST);
    assign w_idx    = IW'(r_col >> KB);

    for (genvar c = 0; c < CI; c++) begin : g_lane
        pool_acc_lane #(
            .IF_BW (IF_BW),
            .SH    (2*KB),
            .ACC_W (ACC_W),
            .DEPTH (OUT_W),
            .IW    (IW)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .i_en     (w_en),
            .i_first  (w_first),
            .i_mode   (w_mode),
            .i_idx    (w_idx),
            .i_sample (i_in_pix[c*IF_BW +: IF_BW]),
            .o_res    (w_res[c*IF_BW +: IF_BW])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= POOL_MAX;
        end else if (w_accept) begin
            if (w_frame_start)
                r_mode <= w_mode;
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ot_valid <= 1'b0;
            r_ot_last  <= 1'b0;
            r_ot_pix   <= '0;
        end else if (w_done) begin
            r_ot_valid <= 1'b1;
            r_ot_last  <= w_last;
            r_ot_pix   <= w_res;
        end else if (i_ot_ready) begin
            r_ot_valid <= 1'b0;
        end
    end

    assign o_ot_valid = r_ot_valid;
    assign o_ot_last  = r_ot_last;
    assign o_ot_pix   = r_ot_pix;

endmodule

// File: tb/tb_stream_pool.sv
module tb_stream_pool;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: CI=1, 4x4, K=2
    logic       a_mode, a_in_valid, a_in_ready, a_ot_valid, a_ot_ready, a_ot_last;
    logic [7:0] a_in_pix, a_ot_pix;
    // DUT B: CI=2, 5x5, K=2
    logic        b_mode, b_in_valid, b_in_ready, b_ot_valid, b_ot_ready, b_ot_last;
    logic [15:0] b_in_pix, b_ot_pix;

    stream_pool #(.CI(1), .IF_BW(8), .IN_W(4), .IN_H(4), .POOL_K(2)) dut_a (
        .clk(clk), .reset(rst), .i_mode(a_mode),
        .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_pix(a_in_pix),
        .o_ot_valid(a_ot_valid), .i_ot_ready(a_ot_ready), .o_ot_pix(a_ot_pix),
        .o_ot_last(a_ot_last)
    );

    stream_pool #(.CI(2), .IF_BW(8), .IN_W(5), .IN_H(5), .POOL_K(2)) dut_b (
        .clk(clk), .reset(rst), .i_mode(b_mode),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_pix(b_in_pix),
        .o_ot_valid(b_ot_valid), .i_ot_ready(b_ot_ready), .o_ot_pix(b_ot_pix),
        .o_ot_last(b_ot_last)
    );

    typedef struct {
        logic [15:0] pix;
        logic        last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // 4x4 frame: row0 = 1,-5,7,2 ; row1 = 3,0,-8,9 ; rows 2-3 = -1
    logic [7:0]  fa     [16] = '{8'd1, 8'hFB, 8'd7, 8'd2, 8'd3, 8'd0, 8'hF8, 8'd9,
                                 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0]  ea_max [4]  = '{8'd3, 8'd9, 8'hFF, 8'hFF};
    logic [7:0]  ea_avg [4]  = '{8'hFF, 8'd2, 8'hFF, 8'hFF};
    // 5x5 frame, n = r*5+c: ch0 = n-12, ch1 = 12-n, column 4 / row 4 = 127
    logic [15:0] eb_max [4]  = '{16'h0CFA, 16'h0AFC, 16'h0204, 16'h0006};
    logic [15:0] eb_avg [4]  = '{16'h09F7, 16'h07F9, 16'hFF01, 16'hFD03};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (a_ot_valid && a_ot_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_output", 32'(a_ot_pix), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_pix", 32'(a_ot_pix), 32'(e.pix[7:0]));
                chk("a_last", 32'(a_ot_last), 32'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        if (b_ot_valid && b_ot_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_output", 32'(b_ot_pix), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_pix", 32'(b_ot_pix), 32'(e.pix));
                chk("b_last", 32'(b_ot_last), 32'(e.last));
            end
        end
    end

    task automatic send_a(input logic [7:0] p, input bit done);
        int n;
        n = 0;
        a_in_valid = 1'b1;
        a_in_pix   = p;
        @(negedge clk);
        while (!a_in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("a_in_ready_timeout", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        if (done) chk("a_latency", 32'(a_ot_valid), 32'd1);
    endtask

    task automatic send_b(input logic [15:0] p, input bit done);
        int n;
        n = 0;
        b_in_valid = 1'b1;
        b_in_pix   = p;
        @(negedge clk);
        while (!b_in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("b_in_ready_timeout", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        if (done) chk("b_latency", 32'(b_ot_valid), 32'd1);
    endtask

    // Mode is 'avg' for pixels before sw_at, inverted afterwards.
    task automatic frame_a(input bit avg, input int npix, input int sw_at);
        int   k;
        bit   done;
        exp_t e;
        k = 0;
        for (int i = 0; i < npix; i++) begin
            done   = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
            a_mode = (i < sw_at) ? avg : !avg;
            if (done) begin
                e.pix  = {8'h00, (avg ? ea_avg[k] : ea_max[k])};
                e.last = (k == 3);
                qa.push_back(e);
                k++;
            end
            send_a(fa[i], done);
        end
    endtask

    task automatic frame_b(input bit avg);
        int         k;
        int         n;
        bit         done;
        exp_t       e;
        logic [7:0] c0, c1;
        k = 0;
        b_mode = avg;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                n    = r * 5 + c;
                done = (r < 4) && (c < 4) && (r % 2 == 1) && (c % 2 == 1);
                if (r == 4 || c == 4) begin
                    c0 = 8'd127;
                    c1 = 8'd127;
                end else begin
                    c0 = 8'(n - 12);
                    c1 = 8'(12 - n);
                end
                if (done) begin
                    e.pix  = avg ? eb_avg[k] : eb_max[k];
                    e.last = (k == 3);
                    qb.push_back(e);
                    k++;
                end
                send_b({c1, c0}, done);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        a_mode     = 1'b0;
        a_in_valid = 1'b0;
        a_in_pix   = '0;
        a_ot_ready = 1'b1;
        b_mode     = 1'b0;
        b_in_valid = 1'b0;
        b_in_pix   = '0;
        b_ot_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_a_valid", 32'(a_ot_valid), 32'd0);
        chk("rst_a_pix",   32'(a_ot_pix),   32'd0);
        chk("rst_a_last",  32'(a_ot_last),  32'd0);
        chk("rst_a_ready", 32'(a_in_ready), 32'd1);
        chk("rst_b_valid", 32'(b_ot_valid), 32'd0);
        chk("rst_b_pix",   32'(b_ot_pix),   32'd0);

        // Max then average on the 4x4 frame
        frame_a(1'b0, 16, 16);
        frame_a(1'b1, 16, 16);

        // Backpressure on the first output of a max frame
        fork
            frame_a(1'b0, 16, 16);
            begin : bp
                int n;
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!a_ot_valid && n < 100);
                if (n >= 100) chk("bp_wait_timeout", 32'(a_ot_valid), 32'd1);
                a_ot_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_valid",    32'(a_ot_valid), 32'd1);
                    chk("bp_pix",      32'(a_ot_pix),   32'd3);
                    chk("bp_in_ready", 32'(a_in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                a_ot_ready = 1'b1;
            end
        join

        // Reset after 6 pixels (one window completed), then a fresh frame
        frame_a(1'b0, 6, 16);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_a_valid", 32'(a_ot_valid), 32'd0);
        chk("midrst_a_ready", 32'(a_in_ready), 32'd1);
        frame_a(1'b0, 16, 16);

        // Back-to-back frames: mode flips at pixel 3 of frame 1 (ignored)
        frame_a(1'b0, 16, 3);
        frame_a(1'b1, 16, 16);

        // 5x5 two-channel frames with discarded trailing column/row
        frame_b(1'b0);
        frame_b(1'b1);

        repeat (5) @(negedge clk);
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_pool.md
STREAM_POOL -- requirements
Module: stream_pool

Interface
REQ-001 SHALL have parameter CI, default 3: number of channels processed in parallel.
REQ-002 SHALL have parameter IF_BW, default 8: signed two's-complement bits per channel sample.
REQ-003 SHALL have parameter IN_W, default 28: input frame width in pixels.
REQ-004 SHALL have parameter IN_H, default 28: input frame height in pixels.
REQ-005 SHALL have parameter POOL_K, default 2: window size and stride, legal values 2 and 4 only.
REQ-006 SHALL have port clk  input  1: the only clock, rising-edge.
REQ-007 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-008 SHALL have port i_mode  input  1: 0 = max pooling, 1 = average pooling.
REQ-009 SHALL have port i_in_valid  input  1: input pixel valid.
REQ-010 SHALL have port o_in_ready  output  1: block accepts the input pixel this cycle.
REQ-011 SHALL have port i_in_pix  input  CI*IF_BW: one pixel, channel c at bits [c*IF_BW +: IF_BW].
REQ-012 SHALL have port o_ot_valid  output  1: pooled pixel valid.
REQ-013 SHALL have port i_ot_ready  input  1: downstream accepts the pooled pixel.
REQ-014 SHALL have port o_ot_pix  output  CI*IF_BW: pooled pixel, same channel packing as the input.
REQ-015 SHALL have port o_ot_last  output  1: high with the final pooled pixel of a frame.

Function
REQ-016 SHALL accept input pixels in raster order (column fastest); transfer occurs when i_in_valid and o_in_ready are both high.
REQ-017 SHALL define OUT_W = floor(IN_W/POOL_K) and OUT_H = floor(IN_H/POOL_K); pixels in trailing columns or rows outside the last full window SHALL be accepted and discarded.
REQ-018 SHALL keep column counter col (0..IN_W-1) and row counter row (0..IN_H-1); col wraps to 0 and row increments on each accepted pixel at col=IN_W-1; both wrap to 0 after the pixel at (IN_W-1, IN_H-1).
REQ-019 SHALL sample i_mode only when an accepted pixel has col=0 and row=0, and hold it for the whole frame.
REQ-020 SHALL keep one partial-result buffer of OUT_W entries, each CI accumulators, indexed by col/POOL_K.
REQ-021 SHALL, in max mode, initialise the accumulator with the first pixel of its window and replace it when a new sample is signed-greater than the stored value.
REQ-022 SHALL, in average mode, use accumulators of IF_BW+2*log2(POOL_K) bits, sign-extended, that sum all POOL_K*POOL_K samples exactly.
REQ-023 SHALL emit the average as an arithmetic right shift of the sum by 2*log2(POOL_K) (floor toward minus infinity), truncated to IF_BW.
REQ-024 SHALL complete a window when the accepted pixel has col%POOL_K=POOL_K-1 and row%POOL_K=POOL_K-1, inside the first OUT_W*POOL_K columns and OUT_H*POOL_K rows.
REQ-025 SHALL assert o_ot_valid in the cycle after the window-completing pixel is accepted, including that pixel in the result (1-cycle latency).
REQ-026 SHALL hold o_ot_valid, o_ot_pix and o_ot_last stable until i_ot_ready is high.
REQ-027 SHALL drive o_in_ready = NOT(o_ot_valid AND NOT i_ot_ready), so a completing pixel may be accepted in the same cycle as the held output is consumed.
REQ-028 SHALL assert o_ot_last with the pooled pixel at output position (OUT_W-1, OUT_H-1).
REQ-029 SHALL need no idle cycles between frames: the first pixel of frame N+1 may follow the last pixel of frame N back-to-back.

Reset
REQ-030 SHALL, on reset high at a rising clk edge, clear col, row, the stored mode and all accumulators to 0, and drive o_ot_valid=0, o_ot_last=0 and o_ot_pix=0.
REQ-031 SHALL, on reset mid-frame, discard the partial frame; the next accepted pixel is treated as (0,0).
REQ-032 SHALL drive o_in_ready high in the first cycle after reset is released.

Structure
REQ-033 SHALL take CI, IF_BW and POOL_K defaults, the mode encoding and the legal POOL_K set from the shared CNN defines file.
REQ-034 SHALL derive OUT_W, OUT_H and the accumulator width locally as localparams.
REQ-035 SHALL use one sub-module pool_acc_lane, one instance per channel, containing that channel's compare/accumulate datapath and final-shift datapath.

Verification
REQ-036 SHALL cover this case: CI=1, IF_BW=8, IN_W=IN_H=4, K=2, max mode, row 0 = 1,-5,7,2, row 1 = 3,0,-8,9, rows 2-3 all -1 -> outputs 3, 9, -1, -1, with o_ot_last on the 4th output.
REQ-037 SHALL cover this case: same frame in average mode -> outputs floor(-1/4) = -1, floor(10/4) = 2, -1, -1.
REQ-038 SHALL cover this case: CI=2, IN_W=5, IN_H=5, K=2 -> exactly 4 outputs per frame; column 4 and row 4 values (set to 127) never appear in the outputs.
REQ-039 SHALL cover this case: i_ot_ready held low for 5 cycles while an output is pending -> o_ot_pix stable, o_in_ready low, no pixel lost or duplicated.
REQ-040 SHALL cover this case: reset asserted after 6 pixels of a frame, then a full new frame -> outputs match a fresh frame, first output 1 cycle after its completing pixel.
REQ-041 SHALL cover this case: two back-to-back frames with i_mode switching 0 -> 1 mid-frame 1 -> frame 1 stays max mode, frame 2 is average mode.
